// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the four-master bus arbiter.
// Carries the bus ownership constants (bus_def) and the active-low
// enable/disable levels (global_std_def) used by the arbiter and its neighbours.
package bus_arbiter_pkg;

  // Active-low signalling levels shared across the bus fabric.
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam int unsigned BUS_MASTER_CH = 4;

  typedef logic [1:0] bus_owner_t;

  localparam bus_owner_t BUS_OWNER_MASTER_0 = 2'd0;
  localparam bus_owner_t BUS_OWNER_MASTER_1 = 2'd1;
  localparam bus_owner_t BUS_OWNER_MASTER_2 = 2'd2;
  localparam bus_owner_t BUS_OWNER_MASTER_3 = 2'd3;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Round-robin picker for the bus arbiter.
// Purely combinational: searches owner+1, owner+2, owner+3 (mod 4) for the first
// asserted bit of an active-high request vector whose owner bit is already masked.
// Ports:
//   owner - current owner index
//   req   - active-high requests, owner bit cleared by the caller
//   next  - first requester in rotation order (owner when none found)
//   found - at least one other master is requesting
module bus_arbiter_rr_pick
  import bus_arbiter_pkg::*;
(
  input  logic [1:0]               owner,
  input  logic [BUS_MASTER_CH-1:0] req,
  output logic [1:0]               next,
  output logic                     found
);

  always_comb begin
    logic [1:0] idx;
    next  = owner;
    found = 1'b0;
    for (int k = 1; k < BUS_MASTER_CH; k++) begin
      idx = owner + 2'(k);
      if (req[idx] && !found) begin
        next  = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Four-master round-robin bus arbiter.
// Holds one registered owner so exactly one active-low grant is asserted every
// cycle; the bus parks on the last owner when idle. An optional hold limit
// forces rotation to a waiting master, but never while a transaction
// (s_as_n asserted) is in flight.
// Ports:
//   clk, reset_n       - clock, asynchronous active-low reset
//   m0..m3_req_n       - per-master bus requests, active-low
//   s_as_n             - shared address strobe from the bus mux, active-low
//   m0..m3_grnt_n      - per-master grants, active-low, decoded from owner only
//   owner              - current owner index
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned HOLD_W   = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       m0_req_n,
  input  logic       m1_req_n,
  input  logic       m2_req_n,
  input  logic       m3_req_n,
  input  logic       s_as_n,
  output logic       m0_grnt_n,
  output logic       m1_grnt_n,
  output logic       m2_grnt_n,
  output logic       m3_grnt_n,
  output logic [1:0] owner
);

  localparam logic [HOLD_W-1:0] HoldMax = HOLD_W'(MAX_HOLD);

  logic [1:0]               owner_q, owner_d;
  logic [HOLD_W-1:0]        hold_q, hold_d;
  logic [BUS_MASTER_CH-1:0] req;
  logic [BUS_MASTER_CH-1:0] other_req;
  logic                     own_req;
  logic [1:0]               pick_next;
  logic                     pick_found;
  logic                     force_rot;
  logic [BUS_MASTER_CH-1:0] grnt_n;

  assign req       = ~{m3_req_n, m2_req_n, m1_req_n, m0_req_n};
  assign own_req   = req[owner_q];
  assign other_req = req & ~(BUS_MASTER_CH'(1) << owner_q);

  bus_arbiter_rr_pick u_pick (
    .owner (owner_q),
    .req   (other_req),
    .next  (pick_next),
    .found (pick_found)
  );

  assign force_rot = (MAX_HOLD != 0) && own_req && (hold_q == HoldMax) && pick_found &&
                     (s_as_n == DISABLE_);

  always_comb begin
    owner_d = owner_q;
    hold_d  = hold_q;
    if (pick_found && (!own_req || force_rot)) begin
      owner_d = pick_next;
      hold_d  = '0;
    end else if (!pick_found) begin
      hold_d = '0;
    end else if (hold_q < HoldMax) begin
      // Owner still requesting with someone waiting; saturates at the limit.
      hold_d = hold_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q <= BUS_OWNER_MASTER_0;
      hold_q  <= '0;
    end else begin
      owner_q <= owner_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    for (int i = 0; i < BUS_MASTER_CH; i++) begin
      grnt_n[i] = (owner_q == 2'(i)) ? ENABLE_ : DISABLE_;
    end
  end

  assign m0_grnt_n = grnt_n[0];
  assign m1_grnt_n = grnt_n[1];
  assign m2_grnt_n = grnt_n[2];
  assign m3_grnt_n = grnt_n[3];
  assign owner     = owner_q;

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] req_n = 4'hF;
  logic       s_as_n = 1'b1;

  logic [3:0] grnt_a, grnt_b;
  logic [1:0] owner_a, owner_b;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  // Short hold limit for the corner-case sequences.
  bus_arbiter #(.MAX_HOLD(4), .HOLD_W(3)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .m0_req_n  (req_n[0]),
    .m1_req_n  (req_n[1]),
    .m2_req_n  (req_n[2]),
    .m3_req_n  (req_n[3]),
    .s_as_n    (s_as_n),
    .m0_grnt_n (grnt_a[0]),
    .m1_grnt_n (grnt_a[1]),
    .m2_grnt_n (grnt_a[2]),
    .m3_grnt_n (grnt_a[3]),
    .owner     (owner_a)
  );

  // Default parameters, exercised by the random phase.
  bus_arbiter dut_d (
    .clk       (clk),
    .reset_n   (reset_n),
    .m0_req_n  (req_n[0]),
    .m1_req_n  (req_n[1]),
    .m2_req_n  (req_n[2]),
    .m3_req_n  (req_n[3]),
    .s_as_n    (s_as_n),
    .m0_grnt_n (grnt_b[0]),
    .m1_grnt_n (grnt_b[1]),
    .m2_grnt_n (grnt_b[2]),
    .m3_grnt_n (grnt_b[3]),
    .owner     (owner_b)
  );

  typedef struct {
    logic [3:0] req_n;
    logic       s_as_n;
    int         exp_owner;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Expected active-low one-hot grant pattern for an owner index.
  function automatic int grant_of(input int own);
    return 15 - (1 << own);
  endfunction

  task automatic chk_a(input string name, input int exp_own);
    chk({name, "_owner"}, int'(owner_a), exp_own);
    chk({name, "_grnt"}, int'(grnt_a), grant_of(exp_own));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_n   = 4'hF;
    s_as_n  = 1'b1;
    reset_n = 1'b0;
    #3;
    reset_n = 1'b1;
    tick();
  endtask

  // Reference model from the arbitration rules: rotation search by modular
  // arithmetic, hold measured as cycles spent waiting behind the owner.
  task automatic model_step(input int own, input int hold, input logic [3:0] rq,
                            input bit as_idle, input int maxh,
                            output int nown, output int nhold);
    int cand;
    cand  = -1;
    for (int k = 1; k < 4; k++) begin
      if (cand < 0 && rq[(own + k) % 4]) cand = (own + k) % 4;
    end
    nown  = own;
    nhold = hold;
    if (cand < 0) begin
      nhold = 0;
    end else if (!rq[own] || (maxh != 0 && hold == maxh && as_idle)) begin
      nown  = cand;
      nhold = 0;
    end else if (hold < maxh) begin
      nhold = hold + 1;
    end
  endtask

  vec_t vecs[13];

  initial begin
    int mo_a, mh_a, mo_b, mh_b, no, nh;
    logic [3:0] rq;

    vecs[0]  = '{4'b1111, 1'b1, 0};
    vecs[1]  = '{4'b1011, 1'b1, 2};  // parked bus, m2 asks
    vecs[2]  = '{4'b0010, 1'b1, 2};  // m0,m2,m3 ask, owner keeps it
    vecs[3]  = '{4'b0110, 1'b1, 3};  // m2 releases -> m3
    vecs[4]  = '{4'b1110, 1'b1, 0};  // m3 releases -> m0
    vecs[5]  = '{4'b1011, 1'b1, 2};  // m0 releases, m2 re-asks
    vecs[6]  = '{4'b1111, 1'b1, 2};  // parked on m2
    vecs[7]  = '{4'b0101, 1'b1, 3};  // m1,m3 together: m3 first from owner+1
    vecs[8]  = '{4'b1101, 1'b1, 1};
    vecs[9]  = '{4'b1110, 1'b1, 0};  // m1 drops, m0 waiting
    vecs[10] = '{4'b1100, 1'b1, 0};  // m1 re-asks behind owner m0
    vecs[11] = '{4'b1101, 1'b1, 1};
    vecs[12] = '{4'b1111, 1'b1, 1};

    // Reset state, during and after reset.
    req_n = 4'hF;
    #2;
    chk_a("reset_during", 0);
    #4;
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_owner", int'(owner_a), 0);
    end
    chk_a("idle_after", 0);

    // Table-driven rotation sequence.
    do_reset();
    for (int i = 0; i < 13; i++) begin
      req_n  = vecs[i].req_n;
      s_as_n = vecs[i].s_as_n;
      tick();
      chk_a($sformatf("vec%0d", i), vecs[i].exp_owner);
    end

    // Forced rotation: counter 0..4 then rotate on the fifth edge.
    do_reset();
    req_n = 4'b1101;
    tick();
    chk_a("force_setup", 1);
    req_n = 4'b0101;
    for (int e = 1; e <= 5; e++) begin
      tick();
      chk($sformatf("force_edge%0d", e), int'(owner_a), (e < 5) ? 1 : 3);
    end

    // Transaction in flight blocks rotation until the strobe deasserts.
    do_reset();
    req_n = 4'b1101;
    tick();
    req_n  = 4'b0101;
    s_as_n = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      chk($sformatf("as_hold%0d", e), int'(owner_a), 1);
    end
    s_as_n = 1'b1;
    tick();
    chk_a("as_release", 3);

    // Asynchronous reset mid-cycle while owner 3 has m0/m1 waiting.
    do_reset();
    req_n = 4'b0111;
    tick();
    chk_a("ar_setup", 3);
    req_n = 4'b0100;
    tick();
    #3;
    reset_n = 1'b0;
    #1;
    chk_a("ar_async", 0);
    #2;
    reset_n = 1'b1;
    req_n = 4'b1100;
    // A cleared counter means no forced rotation for four edges.
    for (int e = 1; e <= 4; e++) begin
      tick();
      chk($sformatf("ar_hold%0d", e), int'(owner_a), 0);
    end
    req_n = 4'b1101;
    tick();
    chk_a("ar_resume", 1);

    // Random phase, both instances against the reference model.
    do_reset();
    mo_a = 0; mh_a = 0; mo_b = 0; mh_b = 0;
    for (int c = 0; c < 3000; c++) begin
      rq     = 4'($urandom_range(0, 15));
      req_n  = ~rq;
      s_as_n = ($urandom_range(0, 3) != 0);
      model_step(mo_a, mh_a, rq, s_as_n, 4, no, nh);
      mo_a = no; mh_a = nh;
      model_step(mo_b, mh_b, rq, s_as_n, 16, no, nh);
      mo_b = no; mh_b = nh;
      tick();
      chk("rand_owner_a", int'(owner_a), mo_a);
      chk("rand_owner_b", int'(owner_b), mo_b);
      chk("rand_grnt_b", int'(grnt_b), grant_of(mo_b));
    end

    // Long holds so the default 16-cycle limit and strobe blocking are reached.
    for (int c = 0; c < 400; c++) begin
      rq     = (c % 60 < 50) ? 4'b1111 : 4'($urandom_range(0, 15));
      req_n  = ~rq;
      s_as_n = ((c % 37) > 30) ? 1'b0 : 1'b1;
      model_step(mo_a, mh_a, rq, s_as_n, 4, no, nh);
      mo_a = no; mh_a = nh;
      model_step(mo_b, mh_b, rq, s_as_n, 16, no, nh);
      mo_b = no; mh_b = nh;
      tick();
      chk("hold_owner_a", int'(owner_a), mo_a);
      chk("hold_owner_b", int'(owner_b), mo_b);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Four-master round-robin bus arbiter. Sits directly upstream of bus_master_mux and drives its m0..m3_grnt_n inputs.
- Samples per-master request lines and keeps one registered owner, so exactly one grant is active every cycle.
- Optional hold limit forces ownership to rotate between transactions when other masters are waiting.

Parameters:
- MAX_HOLD, 16, cycles an owner may hold the bus while another master requests before rotation is forced; 0 disables the limit.
- HOLD_W, 5, width of the hold counter; must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- m0_req_n  input  1  master 0 bus request, active-low (`ENABLE_` = 0).
- m1_req_n  input  1  master 1 bus request, active-low.
- m2_req_n  input  1  master 2 bus request, active-low.
- m3_req_n  input  1  master 3 bus request, active-low.
- s_as_n  input  1  shared address strobe fed back from bus_master_mux output; `ENABLE_` means a transaction is in flight.
- m0_grnt_n  output  1  grant to master 0, active-low.
- m1_grnt_n  output  1  grant to master 1, active-low.
- m2_grnt_n  output  1  grant to master 2, active-low.
- m3_grnt_n  output  1  grant to master 3, active-low.
- owner  output  2  current owner index, for debug and visibility.

Behaviour:
- Clock and reset: one clock, clk. Reset is reset_n, asynchronous, active-low.
- State registers: owner[1:0] and hold_cnt[HOLD_W-1:0].
- Reset (asynchronous, also mid-operation):
  - owner = 0, hold_cnt = 0.
  - Outputs go immediately to m0_grnt_n = `ENABLE_`, m1..m3_grnt_n = `DISABLE_`, owner = 2'd0.
  - No partial rotation survives reset.
- Grant decode:
  - mi_grnt_n = `ENABLE_` iff owner == i. Decoded only from the owner register; no combinational path from req to grnt.
  - Exactly one grant is active in every cycle (one-hot-low), including idle. The bus parks on the last owner.
- Next-owner rule, evaluated each rising edge:
  - Release: owner's req_n = `DISABLE_`. Next owner is the first requesting master in the order owner+1, owner+2, owner+3 (mod 4). If none requests, owner is unchanged (parked).
  - Forced rotation: all of the following hold —
    - MAX_HOLD != 0;
    - owner's req_n = `ENABLE_`;
    - hold_cnt == MAX_HOLD;
    - at least one other master requests;
    - s_as_n = `DISABLE_`.
    Then owner moves to the first other requester, same search order as release.
  - Otherwise owner holds.
- Latency:
  - Request to a free (parked, non-requesting) bus: grant one cycle after req is sampled.
  - Handover on release: new grant visible the cycle after the owner's req_n is sampled `DISABLE_`.
- hold_cnt:
  - Cleared to 0 on any owner change.
  - Cleared to 0 whenever no other master requests.
  - Otherwise increments while the owner requests and another master waits.
  - Saturates at MAX_HOLD, never wraps.
- Transaction protection: forced rotation never occurs while s_as_n = `ENABLE_`. The counter stays saturated until s_as_n deasserts, and rotation happens on that edge.
- Simultaneous events:
  - Release and forced rotation in the same cycle resolve identically (same search order).
  - Several new requesters resolve strictly by rotation order from owner+1, never by fixed index priority.
- Owner self-request after release: an owner that drops req_n and re-asserts it is served only after every other master requesting in between has been served.

Decomposition:
- Shared package bus_def:
  - `BUS_MASTER_CH` = 4
  - `BUS_OWNER_BUS` = [1:0]
  - `BUS_OWNER_MASTER_0` .. `BUS_OWNER_MASTER_3`
- `ENABLE_` / `DISABLE_` come from global_std_def.
- One sub-module is natural: bus_arb_rr_pick. It is purely combinational: takes owner and a 4-bit active-high request vector (current owner masked) and returns next index plus a found flag.
- The top module holds the owner and counter registers and does the grant decode.

Test Plan:
- Reset pulse with all req_n = 1 -> m0_grnt_n = 0, m1..m3 = 1, owner = 0 during and after reset; owner stays 0 for 10 idle cycles.
- Owner 0 idle, assert m2_req_n = 0 at t -> owner = 2 and m2_grnt_n = 0 on the first edge after sampling; all other grants high.
- Owner 2; m2, m3, m0 all request; m2 releases -> owner 3. m3 releases -> owner 0. m0 releases with m2 re-requesting -> owner 2. Rotation order is confirmed.
- MAX_HOLD = 4, owner 1 holds req with s_as_n = 1, m3 requests -> owner becomes 3 exactly 5 edges after m3_req_n asserts (counter 0..4, then rotate).
- Same as previous but s_as_n = 0 for 10 cycles -> owner stays 1; rotation to 3 occurs on the first edge with s_as_n = 1.
- Owner 3 with m0 and m1 requesting, reset_n pulsed low mid-cycle -> grants switch to m0 asynchronously; hold_cnt = 0; after release, arbitration resumes from owner 0 (next grant m1 once m0 releases).
